// File: rtl/ascii_num_tx.sv
// Purpose: converts a binary value to decimal ASCII (double dabble) and feeds it bytewise to a UART transmitter.
// Latency: first tx_en VALUE_BITS+2 cycles after start is sampled, then one byte every 3 cycles; done 2 cycles after the last tx_en.
// Backpressure: SEND waits while tx_busy=1; tx_en is gated by !tx_busy so it never fires while the transmitter is busy.
// Optional feature: define ASCII_NUM_TX_CRLF_EN to append CR (0x0D) and LF (0x0A) after the last digit.
module ascii_num_tx #(
    parameter int VALUE_BITS = 16,
    parameter int DIGITS     = 5
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [VALUE_BITS-1:0] value,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    input  logic                  tx_busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VALUE_BITS + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        LOAD,
        SEND,
        HOLD,
        FIN
    } state_t;

    state_t                state;
    logic [VALUE_BITS-1:0] sreg;      // latched value, shifted out MSB first during CONV
    logic [BW-1:0]         bcd;       // BCD accumulator, digit 0 in the low nibble
    logic [BW-1:0]         bcd_adj;   // bcd with +3 applied to every nibble >= 5
    logic [CW-1:0]         bit_cnt;
    logic [IW-1:0]         dig_idx;   // next digit to send after the first one
    logic [IW-1:0]         msd_idx;   // index of the most significant non-zero digit
    logic [IW-1:0]         cur_idx;
    logic [3:0]            cur_dig;
    logic                  first;     // next LOAD is the first digit of this report
    logic                  more;      // another byte follows the one being sent

`ifdef ASCII_NUM_TX_CRLF_EN
    typedef enum logic [1:0] {
        PH_DIG,
        PH_CR,
        PH_LF
    } phase_t;

    phase_t phase;
`endif

    // Add-3 correction of every BCD nibble ahead of the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Locate the leading non-zero digit; an all-zero value yields digit 0 so "0" is still sent
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd_idx = IW'(i);
            end
        end
    end

    // Digit selected by the current LOAD: leading digit first, then walk downwards
    always_comb begin
        cur_idx = first ? msd_idx : dig_idx;
        cur_dig = bcd[{cur_idx, 2'b00} +: 4];
    end

    // Strobe only in a SEND cycle where the transmitter is free, so it can never overlap tx_busy
    assign tx_en = (state == SEND) && !tx_busy;

    // Report sequencer: latch, convert, then LOAD/SEND/HOLD per byte, FIN pulses done
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sreg    <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            dig_idx <= '0;
            first   <= 1'b0;
            more    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            tx_data <= 8'h00;
`ifdef ASCII_NUM_TX_CRLF_EN
            phase   <= PH_DIG;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg    <= value;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CONV;
`ifdef ASCII_NUM_TX_CRLF_EN
                        phase   <= PH_DIG;
`endif
                    end
                end

                CONV: begin
                    // One double-dabble step: correct, then shift the next value bit into the BCD LSB
                    {bcd, sreg} <= {bcd_adj, sreg} << 1;
                    bit_cnt     <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(VALUE_BITS - 1)) begin
                        first <= 1'b1;
                        state <= LOAD;
                    end
                end

                LOAD: begin
                    state <= SEND;
`ifdef ASCII_NUM_TX_CRLF_EN
                    if (phase == PH_CR) begin
                        tx_data <= 8'h0D;
                        phase   <= PH_LF;
                        more    <= 1'b1;
                    end else if (phase == PH_LF) begin
                        tx_data <= 8'h0A;
                        more    <= 1'b0;
                    end else begin
                        tx_data <= 8'h30 + {4'h0, cur_dig};
                        first   <= 1'b0;
                        dig_idx <= cur_idx - 1'b1;
                        more    <= 1'b1;
                        if (cur_idx == '0) begin
                            phase <= PH_CR;
                        end
                    end
`else
                    tx_data <= 8'h30 + {4'h0, cur_dig};
                    first   <= 1'b0;
                    dig_idx <= cur_idx - 1'b1;
                    more    <= (cur_idx != '0);
`endif
                end

                SEND: begin
                    if (!tx_busy) begin
                        state <= HOLD;
                    end
                end

                HOLD: begin
                    // Gives the transmitter one cycle to raise tx_busy before the next SEND
                    if (more) begin
                        state <= LOAD;
                    end else begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_num_tx.sv
// Bench for ascii_num_tx: directed and random reports compared against a decimal-string reference.
// Cycle numbering: cycle 0 is the cycle in which start=1 is presented to the DUT.
// A small UART model raises tx_busy for a programmable number of cycles after each tx_en.
module tb_ascii_num_tx;

    localparam int VB = 16;
    localparam int DG = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [VB-1:0] value;
    logic          busy;
    logic          done;
    logic [7:0]    tx_data;
    logic          tx_en;
    logic          tx_busy;

    logic force_busy = 1'b0;
    int   uart_len   = 0;
    int   uart_cnt   = 0;
    bit   pend       = 1'b0;

    int           cyc = 0;
    byte unsigned got_b[$];
    int           got_c[$];
    int           done_cnt = 0;
    int           done_cyc = 0;
    int           viol     = 0;

    int           checks = 0;
    int           errors = 0;
    int           base;
    int           start_cyc;
    int           d0;
    byte unsigned exp_q[$];

    ascii_num_tx #(
        .VALUE_BITS(VB),
        .DIGITS    (DG)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .tx_data(tx_data),
        .tx_en  (tx_en),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    assign tx_busy = force_busy || (uart_cnt != 0);

    // cycle counter and transmitter busy model
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pend) uart_cnt <= uart_len;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end

    // byte/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        pend = tx_en;
        if (tx_en) begin
            got_b.push_back(tx_data);
            got_c.push_back(cyc);
            if (tx_busy) viol++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal text of v, optionally followed by CR LF
    function automatic void build(input int v);
        string s;
        s = $sformatf("%0d", v);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
`ifdef ASCII_NUM_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endfunction

    task automatic launch(input int v);
        @(posedge clk);
        #1;
        value     = v[VB-1:0];
        start     = 1'b1;
        start_cyc = cyc;
        base      = got_b.size();
        d0        = done_cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        value = VB'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_pulses", 32'(done_cnt), 32'(d0 + 1));
        @(posedge clk);
        #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_low_after", 32'(done), 32'd0);
    endtask

    task automatic check_bytes(input int v, input bit timing);
        int n;
        build(v);
        n = exp_q.size();
        chk($sformatf("nbytes_%0d", v), 32'(got_b.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < got_b.size()) begin
                chk($sformatf("byte%0d_of_%0d", i, v), 32'(got_b[base+i]), 32'(exp_q[i]));
                if (timing)
                    chk($sformatf("en_cyc%0d_of_%0d", i, v), 32'(got_c[base+i] - start_cyc), 32'(VB + 2 + 3*i));
            end
        end
        if (timing) chk($sformatf("done_cyc_%0d", v), 32'(done_cyc - start_cyc), 32'(VB + 2 + 3*(n-1) + 2));
    endtask

    initial begin
        int v;
        int n;

        resetn = 1'b1;
        start  = 1'b0;
        value  = '0;
        #2;
        resetn = 1'b0;
        #1;
        // async reset state, before any clock edge
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_en", 32'(tx_en), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // directed values with exact timing
        uart_len = 0;
        launch(1600); wait_done(); check_bytes(1600, 1'b1);
        launch(0);    wait_done(); check_bytes(0, 1'b1);
        launch(65535); wait_done(); check_bytes(65535, 1'b1);

        // random values with a random transmitter busy length
        repeat (10) begin
            uart_len = int'($urandom_range(0, 6));
            v        = int'($urandom_range(0, 65535));
            launch(v);
            wait_done();
            check_bytes(v, uart_len == 0);
        end

        // transmitter busy for a long window covering the first SEND
        uart_len = 0;
        launch(1600);
        while (cyc < start_cyc + VB + 1) begin @(posedge clk); #1; end
        force_busy = 1'b1;
        while (cyc < start_cyc + VB + 102) begin @(posedge clk); #1; end
        force_busy = 1'b0;
        wait_done();
        check_bytes(1600, 1'b0);
        if (got_b.size() > base + 1) begin
            chk("busy_win_first_en", 32'(got_c[base] - start_cyc), 32'(VB + 102));
            chk("busy_win_spacing", 32'(got_c[base+1] - got_c[base]), 32'd3);
        end else begin
            chk("busy_win_bytes", 32'(got_b.size() - base), 32'd4);
        end

        // start while busy is ignored
        launch(825);
        repeat (5) @(posedge clk);
        #1; start = 1'b1; value = 16'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        #1; start = 1'b1; value = 16'd7;
        @(posedge clk); #1; start = 1'b0;
        wait_done();
        check_bytes(825, 1'b1);
        repeat (40) @(posedge clk);
        #1;
        chk("ignored_start_bytes", 32'(got_b.size() - base), 32'd3);
        chk("ignored_start_done", 32'(done_cnt), 32'(d0 + 1));
        chk("ignored_start_busy", 32'(busy), 32'd0);

        // reset in the middle of a report
        launch(12345);
        n = 0;
        while (got_b.size() < base + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rst_mid_two_bytes", 32'(got_b.size() - base), 32'd2);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_mid_tx_en", 32'(tx_en), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_tx_data", 32'(tx_data), 32'h00);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("rst_mid_no_more", 32'(got_b.size() - base), 32'd2);
        launch(42); wait_done(); check_bytes(42, 1'b1);

        chk("no_en_while_busy", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ascii_num_tx.md
ASCII_NUM_TX -- requirements
Module: ascii_num_tx

Interface
REQ-001 The block SHALL have parameter VALUE_BITS, default 16, the width of the binary value to be reported.
REQ-002 The block SHALL have parameter DIGITS, default 5, the number of BCD digits produced; DIGITS SHALL cover 2^VALUE_BITS-1.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request to report value; sampled only in IDLE.
REQ-006 The block SHALL have port value, input, VALUE_BITS, an unsigned binary number latched on an accepted start.
REQ-007 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse when the last byte is handed off.
REQ-009 The block SHALL have port tx_data, output, 8, the ASCII byte offered to the UART transmitter.
REQ-010 The block SHALL have port tx_en, output, 1, a one-cycle strobe, equivalent to uart_tx_en.
REQ-011 The block SHALL have port tx_busy, input, 1, the UART transmitter busy flag, equivalent to uart_tx_busy.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, CONV, LOAD, SEND, HOLD and FIN.
REQ-013 In IDLE, start=1 SHALL latch value, clear the BCD register, and enter CONV on the same edge.
REQ-014 CONV SHALL run a shift-add-3 (double dabble) conversion, one bit per cycle, for exactly VALUE_BITS cycles, then enter LOAD.
  - The add-3 step SHALL be applied to every BCD nibble >=5 before each shift.
REQ-015 LOAD SHALL select the next character, most-significant digit first, as 0x30+digit, then enter SEND.
  - Leading zero digits SHALL be skipped.
  - Value 0 SHALL emit the single character 0x30.
REQ-016 SEND SHALL hold tx_data stable and assert tx_en for exactly one cycle, the first cycle in which tx_busy=0, then enter HOLD.
REQ-017 HOLD SHALL last exactly one cycle, covering the transmitter's one-cycle busy latency.
  - If characters remain, HOLD SHALL return to LOAD; otherwise it SHALL go to FIN.
REQ-018 FIN SHALL assert done for one cycle and return to IDLE.
REQ-019 When tx_busy=0 throughout, the first tx_en SHALL occur VALUE_BITS+2 cycles after start is sampled.
REQ-020 When tx_busy=0 throughout, successive tx_en strobes SHALL be exactly 3 cycles apart.
REQ-021 start asserted while busy=1 SHALL be ignored, with no queueing.
REQ-022 Changes on value after latching SHALL NOT affect the current report.
REQ-023 tx_en SHALL never be asserted in any cycle where tx_busy=1.

Reset
REQ-024 resetn=0 SHALL immediately force the following, regardless of clk:
  - state=IDLE, busy=0, done=0, tx_en=0, tx_data=0x00;
  - latched value and BCD register cleared.
REQ-025 A reset asserted mid-report SHALL abandon the remaining characters without emitting any further tx_en.
REQ-026 After resetn deasserts, the first accepted start SHALL produce a complete, correct report.

Configuration
REQ-027 Macro ASCII_NUM_TX_CRLF_EN, when defined, SHALL append the two bytes 0x0D then 0x0A after the last digit.
  - Each appended byte SHALL use the same SEND/HOLD handshake as the digits.
  - done SHALL pulse only after 0x0A is handed off.
REQ-028 Without ASCII_NUM_TX_CRLF_EN, only the digit characters SHALL be sent, and no CR/LF logic SHALL be synthesized.

Verification
REQ-029 value=1600, start pulse, tx_busy=0 -> tx_data 0x31,0x36,0x30,0x30 with tx_en at cycles 18,21,24,27 after start; done at cycle 29.
  - With the macro defined, 0x0D,0x0A SHALL follow before done.
REQ-030 value=0 -> the single byte 0x30, then done; value=65535 -> 0x36,0x35,0x35,0x33,0x35.
REQ-031 tx_busy held high for 100 cycles from the first SEND -> no tx_en during that window; tx_en asserts in the first cycle tx_busy=0, and the byte sequence is unchanged.
REQ-032 Second start pulse with value=7 during an active report of 825 -> only 0x38,0x32,0x35 emitted, then busy=0.
REQ-033 resetn pulsed low after the second tx_en of value=12345 -> tx_en=0 and busy=0 immediately, no further bytes; a subsequent start with value=42 emits 0x34,0x32.
